hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the IF/ID/EX front end of the riscv_core. Watches ID-stage operands,
//  the ID branch/jump decision and EX-stage loads. Drives stall, flush and PC-redirect controls
//  for the pc, if_id and id_ex registers. Counts stall cycles and redirects for the CSR
//  performance counters.
// PARAMETERS
//  FLUSH_CYCLES       1   cycles IF/ID is flushed after a redirect (fetch latency), >=1
//  LOAD_STALL_CYCLES  1   bubble cycles inserted per load-use hazard (dmem latency), >=1
//  CNT_W              32  width of the performance counters
// PORTS
//  clk            in   1      core clock
//  rst            in   1      synchronous, active-high reset
//  id_rs1_addr_i  in   5      rs1 of the instruction in ID
//  id_rs2_addr_i  in   5      rs2 of the instruction in ID
//  id_branch_i    in   1      ID branch comparator result: taken
//  id_jump_i      in   1      ID instruction is JAL/JALR (control_jump != 0)
//  ex_rd_addr_i   in   5      rd of the instruction in EX
//  ex_load_i      in   1      EX instruction is a load writing rd
//  mem_busy_i     in   1      dmem/uart access not complete; whole front end must freeze
//  cnt_clr_i      in   1      clear both performance counters
//  pc_stall_o     out  1      hold the PC
//  if_id_stall_o  out  1      hold the IF/ID register
//  if_id_flush_o  out  1      load a NOP into IF/ID
//  id_ex_stall_o  out  1      hold the ID/EX register
//  id_ex_flush_o  out  1      load a bubble into ID/EX
//  pc_sel_o       out  1      1 = next PC is branch_addr, 0 = pc+1
//  stall_cnt_o    out  CNT_W  cycles with pc_stall_o=1
//  flush_cnt_o    out  CNT_W  redirect events taken
//  state_o        out  2      FSM state: 0 RUN, 1 LOAD_STALL, 2 FLUSH, 3 MEM_WAIT
// BEHAVIOUR
//  Reset: state=RUN, cnt=0, both counters 0. With idle inputs all control outputs are 0.
//  Control outputs are combinational from state and current inputs. State, counters and the
//  internal down-counter are registered.
//  load_use = ex_load_i && ex_rd_addr_i!=0 && (ex_rd_addr_i==id_rs1_addr_i || ex_rd_addr_i==id_rs2_addr_i)
//  redirect = id_branch_i || id_jump_i
//  Priority in every state: mem_busy_i > load_use > redirect.
//  freeze (mem_busy_i=1), any state:
//   - pc_stall, if_id_stall and id_ex_stall are 1. All other controls are 0.
//   - Next state is MEM_WAIT. The internal down-counter and the pending state are held.
//  RUN:
//   - load_use: pc_stall, if_id_stall and id_ex_flush are 1. pc_sel is 0 (the redirect is
//     suppressed, because the branch operands are stale).
//     If LOAD_STALL_CYCLES>1: go to LOAD_STALL with cnt=LOAD_STALL_CYCLES-1.
//   - redirect with no load_use: pc_sel and if_id_flush are 1.
//     If FLUSH_CYCLES>1: go to FLUSH with cnt=FLUSH_CYCLES-1.
//   - otherwise all controls are 0.
//  LOAD_STALL: same outputs as load_use in RUN; cnt--. When cnt==1, return to RUN.
//  FLUSH: if_id_flush=1 and all other controls are 0. ID inputs are ignored (ID holds a bubble).
//   cnt--. When cnt==1, return to RUN.
//  MEM_WAIT:
//   - While mem_busy_i=1, freeze.
//   - On the first cycle with mem_busy_i=0, resume the held pending state (RUN, LOAD_STALL or
//     FLUSH) and act exactly as that state in the same cycle.
//  Counters:
//   - stall_cnt increments on every cycle with pc_stall_o=1.
//   - flush_cnt increments on every cycle with pc_sel_o=1.
//   - Both wrap modulo 2^CNT_W.
//   - cnt_clr_i wins over a same-cycle increment (result is 0).
//  rst mid-sequence: next cycle is RUN with counters 0. No partial flush or stall persists.
// TESTING
//  1 Reset, then idle for 5 cycles: every control output 0, state_o=0, both counters 0.
//  2 ex_load_i=1, ex_rd=5, id_rs2=5: pc_stall, if_id_stall and id_ex_flush are 1 for exactly
//    1 cycle, stall_cnt=1. Repeat with ex_rd=0: no stall.
//  3 FLUSH_CYCLES=2, id_branch_i=1 for one cycle: cycle 0 has pc_sel=1 and if_id_flush=1;
//    cycle 1 has if_id_flush=1 and state_o=2; cycle 2 returns to RUN; flush_cnt=1.
//  4 load_use and id_jump_i together: stall only, pc_sel=0. The next cycle, with the hazard
//    gone, redirects: pc_sel=1.
//  5 Enter FLUSH, then mem_busy_i=1 for 3 cycles: 3 frozen cycles (state_o=3) and stall_cnt
//    +3. Then the remaining flush cycle completes.
//  6 CNT_W=4, preload to 15 via 15 stalls, 1 more stall: stall_cnt=0. cnt_clr_i during a
//    stall gives 0. rst in the middle of LOAD_STALL gives RUN.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Front-end hazard sequencer: resolves load-use stalls, branch/jump redirects and
// memory freezes into stall/flush/PC-select controls, and counts stalls and redirects.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES      = 1,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_branch_i,
    input  logic             id_jump_i,
    input  logic [4:0]       ex_rd_addr_i,
    input  logic             ex_load_i,
    input  logic             mem_busy_i,
    input  logic             cnt_clr_i,
    output logic             pc_stall_o,
    output logic             if_id_stall_o,
    output logic             if_id_flush_o,
    output logic             id_ex_stall_o,
    output logic             id_ex_flush_o,
    output logic             pc_sel_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } state_t;

    localparam int MAXC = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES : LOAD_STALL_CYCLES;
    localparam int DC_W = $clog2(MAXC + 1);
    localparam logic [DC_W-1:0] LS_INIT = DC_W'(LOAD_STALL_CYCLES - 1);
    localparam logic [DC_W-1:0] FL_INIT = DC_W'(FLUSH_CYCLES - 1);
    localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);

    state_t            state_q, state_d;
    state_t            pend_q, pend_d;
    state_t            act;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              load_use;
    logic              redirect;

    assign load_use = ex_load_i && (ex_rd_addr_i != 5'd0) &&
                      ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));
    assign redirect = id_branch_i || id_jump_i;

    always_comb begin
        pc_stall_o    = 1'b0;
        if_id_stall_o = 1'b0;
        if_id_flush_o = 1'b0;
        id_ex_stall_o = 1'b0;
        id_ex_flush_o = 1'b0;
        pc_sel_o      = 1'b0;
        state_d       = state_q;
        pend_d        = pend_q;
        dc_d          = dc_q;
        // MEM_WAIT behaves as the state it interrupted once the memory is free
        act           = (state_q == MEM_WAIT) ? pend_q : state_q;

        if (mem_busy_i) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_stall_o = 1'b1;
            state_d       = MEM_WAIT;
            pend_d        = act;
        end else begin
            state_d = act;
            case (act)
                LOAD_STALL: begin
                    pc_stall_o    = 1'b1;
                    if_id_stall_o = 1'b1;
                    id_ex_flush_o = 1'b1;
                    dc_d          = dc_q - DC_ONE;
                    if (dc_q == DC_ONE) state_d = RUN;
                end
                FLUSH: begin
                    if_id_flush_o = 1'b1;
                    dc_d          = dc_q - DC_ONE;
                    if (dc_q == DC_ONE) state_d = RUN;
                end
                default: begin
                    // Stale branch operands during a load-use hazard: suppress the redirect
                    if (load_use) begin
                        pc_stall_o    = 1'b1;
                        if_id_stall_o = 1'b1;
                        id_ex_flush_o = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            dc_d    = LS_INIT;
                        end
                    end else if (redirect) begin
                        pc_sel_o      = 1'b1;
                        if_id_flush_o = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = FLUSH;
                            dc_d    = FL_INIT;
                        end
                    end
                end
            endcase
        end

        stall_cnt_d = cnt_clr_i ? '0 : stall_cnt_q + CNT_W'(pc_stall_o);
        flush_cnt_d = cnt_clr_i ? '0 : flush_cnt_q + CNT_W'(pc_sel_o);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            pend_q      <= RUN;
            dc_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            dc_q        <= dc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two configurations share stimulus and are compared each
// cycle against a bubble-counting reference model, plus directed constant checks.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, ex_rd;
    logic       branch, jump, ex_load, busy, clr;

    logic [5:0] ctl [2];
    logic [3:0] scnt_o [2];
    logic [3:0] fcnt_o [2];
    logic [1:0] st_o [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_branch_i(branch), .id_jump_i(jump),
        .ex_rd_addr_i(ex_rd), .ex_load_i(ex_load), .mem_busy_i(busy), .cnt_clr_i(clr),
        .pc_stall_o(ctl[0][5]), .if_id_stall_o(ctl[0][4]), .if_id_flush_o(ctl[0][3]),
        .id_ex_stall_o(ctl[0][2]), .id_ex_flush_o(ctl[0][1]), .pc_sel_o(ctl[0][0]),
        .stall_cnt_o(scnt_o[0]), .flush_cnt_o(fcnt_o[0]), .state_o(st_o[0])
    );

    hazard_ctrl #(.FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .id_rs1_addr_i(rs1), .id_rs2_addr_i(rs2), .id_branch_i(branch), .id_jump_i(jump),
        .ex_rd_addr_i(ex_rd), .ex_load_i(ex_load), .mem_busy_i(busy), .cnt_clr_i(clr),
        .pc_stall_o(ctl[1][5]), .if_id_stall_o(ctl[1][4]), .if_id_flush_o(ctl[1][3]),
        .id_ex_stall_o(ctl[1][2]), .id_ex_flush_o(ctl[1][1]), .pc_sel_o(ctl[1][0]),
        .stall_cnt_o(scnt_o[1]), .flush_cnt_o(fcnt_o[1]), .state_o(st_o[1])
    );

    // Reference model: remaining bubbles of each kind plus a frozen flag
    int fc_p  [2] = '{2, 3};
    int lsc_p [2] = '{1, 3};
    int ls_left [2];
    int fl_left [2];
    bit frozen  [2];
    int m_scnt  [2];
    int m_fcnt  [2];

    int checks   = 0;
    int failures = 0;

    function automatic bit hazard();
        return ex_load && (ex_rd != 0) && (ex_rd == rs1 || ex_rd == rs2);
    endfunction

    // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, pc_sel}
    function automatic logic [5:0] mexp(int k);
        if (busy)            return 6'b110100;
        if (ls_left[k] > 0)  return 6'b110010;
        if (fl_left[k] > 0)  return 6'b001000;
        if (hazard())        return 6'b110010;
        if (branch || jump)  return 6'b001001;
        return 6'b000000;
    endfunction

    function automatic int mstate(int k);
        if (frozen[k])      return 3;
        if (ls_left[k] > 0) return 1;
        if (fl_left[k] > 0) return 2;
        return 0;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [5:0] e;
            e = mexp(k);
            if (rst) begin
                ls_left[k] <= 0; fl_left[k] <= 0; frozen[k] <= 1'b0;
                m_scnt[k]  <= 0; m_fcnt[k]  <= 0;
            end else begin
                if (busy) begin
                    frozen[k] <= 1'b1;
                end else begin
                    frozen[k] <= 1'b0;
                    if (ls_left[k] > 0)      ls_left[k] <= ls_left[k] - 1;
                    else if (fl_left[k] > 0) fl_left[k] <= fl_left[k] - 1;
                    else if (hazard())       ls_left[k] <= lsc_p[k] - 1;
                    else if (branch || jump) fl_left[k] <= fc_p[k] - 1;
                end
                m_scnt[k] <= clr ? 0 : (m_scnt[k] + int'(e[5])) % 16;
                m_fcnt[k] <= clr ? 0 : (m_fcnt[k] + int'(e[0])) % 16;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ctl[%0d]", k),   32'(ctl[k]),    32'(mexp(k)));
            chk($sformatf("state[%0d]", k), 32'(st_o[k]),   32'(mstate(k)));
            chk($sformatf("scnt[%0d]", k),  32'(scnt_o[k]), 32'(m_scnt[k]));
            chk($sformatf("fcnt[%0d]", k),  32'(fcnt_o[k]), 32'(m_fcnt[k]));
        end
    endtask

    // Apply inputs at negedge, compare just after; the model advances on posedge
    task automatic step(input logic r, input logic ld, input logic [4:0] rd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic br, input logic jp, input logic bz, input logic cl);
        @(negedge clk);
        rst = r; ex_load = ld; ex_rd = rd; rs1 = a1; rs2 = a2;
        branch = br; jump = jp; busy = bz; clr = cl;
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; ex_load = 0; ex_rd = 0; rs1 = 0; rs2 = 0;
        branch = 0; jump = 0; busy = 0; clr = 0;
        repeat (2) @(posedge clk);

        // Idle after reset
        idle(5);
        chk("idle_ctl", 32'(ctl[0]), 32'h0);
        chk("idle_state", 32'(st_o[0]), 32'h0);
        chk("idle_scnt", 32'(scnt_o[0]), 32'h0);
        chk("idle_fcnt", 32'(fcnt_o[0]), 32'h0);

        // Load-use on rs2, then the same with rd=x0
        step(0, 1, 5, 1, 5, 0, 0, 0, 0);
        chk("lu_ctl", 32'(ctl[0]), 32'b110010);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_one_cycle", 32'(ctl[0]), 32'h0);
        chk("lu_scnt", 32'(scnt_o[0]), 32'd1);
        idle(4);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("lu_x0", 32'(ctl[0]), 32'h0);

        // Branch with a two-cycle flush
        idle(4);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        chk("br_c0", 32'(ctl[0]), 32'b001001);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_c1", 32'(ctl[0]), 32'b001000);
        chk("br_c1_state", 32'(st_o[0]), 32'd2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_c2_state", 32'(st_o[0]), 32'd0);
        chk("br_fcnt", 32'(fcnt_o[0]), 32'd1);

        // Load-use together with a jump
        idle(4);
        step(0, 1, 7, 7, 0, 0, 1, 0, 0);
        chk("lu_jmp_ctl", 32'(ctl[0]), 32'b110010);
        step(0, 0, 0, 7, 0, 0, 1, 0, 0);
        chk("jmp_after", 32'(ctl[0][0]), 32'd1);

        // Memory freeze in the middle of a flush
        idle(6);
        step(0, 1, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("frz_ctl", 32'(ctl[0]), 32'b110100);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("frz_state", 32'(st_o[0]), 32'd3);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("frz_resume", 32'(ctl[0]), 32'b001000);
        chk("frz_scnt", 32'(scnt_o[0]), 32'd3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("frz_done", 32'(st_o[0]), 32'd0);

        // Counter wrap, clear during a stall, reset inside LOAD_STALL
        idle(6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) step(0, 1, 3, 3, 0, 0, 0, 0, 0);
        step(0, 1, 3, 3, 0, 0, 0, 0, 0);
        chk("wrap15", 32'(scnt_o[0]), 32'd15);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap0", 32'(scnt_o[0]), 32'd0);
        step(0, 1, 3, 3, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("clr_win", 32'(scnt_o[0]), 32'd0);
        idle(4);
        step(0, 1, 2, 0, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("ls_state_b", 32'(st_o[1]), 32'd1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_state_b", 32'(st_o[1]), 32'd0);
        chk("rst_ctl_b", 32'(ctl[1]), 32'h0);
        chk("rst_scnt_b", 32'(scnt_o[1]), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
